rvm_gpr_writeback: RTL

Writeback queue directly upstream of the 32x32 GPR file. It accepts register results from the ALU and the load/store unit through valid/ready handshakes and buffers them in a 2-entry in-order FIFO. It retires one entry per cycle onto the GPR write port (`rd_wen`/`rd_addr`/`rd_wdata`). It also reports read-after-write hazards on the operand read addresses, so the decode sequencer can stall.

---
 rtl/rvm_gpr_writeback_if.sv | 28 ++
 rtl/rvm_gpr_writeback.sv | 80 ++++++++
 2 files changed

// File: rtl/rvm_gpr_writeback_if.sv
// rvm_gpr_writeback_if: source handshakes, GPR write port and hazard lookup of the writeback queue
interface rvm_gpr_writeback_if;
  logic        clk_req;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        empty;
  modport master (
    output alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata, rs1_addr, rs2_addr,
    input  clk_req, alu_ready, lsu_ready, rd_wen, rd_addr, rd_wdata, rs1_busy, rs2_busy, empty
  );
  modport slave (
    input  alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata, rs1_addr, rs2_addr,
    output clk_req, alu_ready, lsu_ready, rd_wen, rd_addr, rd_wdata, rs1_busy, rs2_busy, empty
  );
endinterface

// File: rtl/rvm_gpr_writeback.sv
// rvm_gpr_writeback: 2-entry in-order writeback FIFO feeding the GPR write port, with RAW hazard flags
module rvm_gpr_writeback #(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               resetn,
  rvm_gpr_writeback_if.slave wb
);
  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic             rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ready, lsu_acc, alu_acc, push, pop;
  logic [4:0]       in_rd;
  logic [31:0]      in_data;
  logic [DEPTH-1:0] vld;
  logic             busy1, busy2;

  assign ready        = cnt_q < 2'(DEPTH);
  assign wb.lsu_ready = ready;
  assign wb.alu_ready = ready && !wb.lsu_valid;
  assign lsu_acc      = wb.lsu_valid && ready;
  assign alu_acc      = wb.alu_valid && ready && !wb.lsu_valid;
  assign in_rd        = lsu_acc ? wb.lsu_rd : wb.alu_rd;
  assign in_data      = lsu_acc ? wb.lsu_wdata : wb.alu_wdata;
  assign push         = (lsu_acc || alu_acc) && in_rd != 5'd0;
  assign pop          = cnt_q != 2'd0;
  assign wb.rd_wen    = pop;
  assign wb.rd_addr   = pop ? addr_q[rptr_q] : 5'd0;
  assign wb.rd_wdata  = pop ? data_q[rptr_q] : 32'd0;
  assign wb.empty     = !pop;
  assign wb.clk_req   = wb.alu_valid || wb.lsu_valid || pop;
  assign wb.rs1_busy  = busy1;
  assign wb.rs2_busy  = busy2;

  // Next state: write the accepted non-x0 result at wptr, retire the head whenever occupied
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = (push && wptr_q == i[0]) ? in_rd : addr_q[i];
      data_d[i] = (push && wptr_q == i[0]) ? in_data : data_q[i];
    end
    wptr_d = push ? !wptr_q : wptr_q;
    rptr_d = pop ? !rptr_q : rptr_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Hazard lookup against occupied entries only, never the incoming source
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = cnt_q == 2'd2 || (cnt_q == 2'd1 && rptr_q == i[0]);
      busy1  = busy1 || (vld[i] && wb.rs1_addr != 5'd0 && addr_q[i] == wb.rs1_addr);
      busy2  = busy2 || (vld[i] && wb.rs2_addr != 5'd0 && addr_q[i] == wb.rs2_addr);
    end
  end

  // FIFO state; reset discards every queued write at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end
endmodule
